// File: rtl/pn_event_queue.sv
// Event buffer in front of the PN controller: a FIFO of {addr,data} events drained one per cycle.
// Latency: an event pushed at edge N appears on oADDR/oDATA after edge N+1 (registered, no bypass).
// Backpressure: in_ready = !full, and an offer while full sets sticky ovf_err. stall freezes the outputs and pops.
//
// Ports: clk/rst (async active-high), in_valid/in_ready/in_addr/in_data (event input),
//        stall (SWU active), o_valid/oADDR/oDATA (to controller), fifo_count, ovf_err.
// Optional feature: define PNQ_SPLIT_EN to split two-neuron spike words into two events.
module pn_event_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_addr,
  input  logic [31:0]   in_data,
  input  logic          stall,
  output logic          o_valid,
  output logic [15:0]   oADDR,
  output logic [31:0]   oDATA,
  output logic [AW:0]   fifo_count,
  output logic          ovf_err
);

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_HI} state_t;

  ev_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state_q, state_d;
  logic          vld_d;
  logic [15:0]   addr_d;
  logic [31:0]   data_d;
  logic          push;
  logic          pop;
  ev_t           head;

`ifdef PNQ_SPLIT_EN
  logic [15:0]   hi_q, hi_d;
`endif

  assign in_ready = (fifo_count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // Storage has no reset: reset only clears the pointers, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: in_addr, data: in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (in_valid && !in_ready) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      o_valid <= 1'b0;
      oADDR   <= 16'h0;
      oDATA   <= 32'h0;
`ifdef PNQ_SPLIT_EN
      hi_q    <= 16'h0;
`endif
    end else begin
      state_q <= state_d;
      o_valid <= vld_d;
      oADDR   <= addr_d;
      oDATA   <= data_d;
`ifdef PNQ_SPLIT_EN
      hi_q    <= hi_d;
`endif
    end
  end

  // Pop only reads entries present before this edge, so push+pop on empty is a plain push.
  always_comb begin
    state_d = state_q;
    vld_d   = o_valid;
    addr_d  = oADDR;
    data_d  = oDATA;
    pop     = 1'b0;
`ifdef PNQ_SPLIT_EN
    hi_d    = hi_q;
`endif
    if (!stall) begin
      if (state_q == S_HI) begin
        // Second half of a split word: same data, no pop.
`ifdef PNQ_SPLIT_EN
        vld_d  = 1'b1;
        addr_d = hi_q;
`endif
        state_d = S_ONE;
      end else if (fifo_count != '0) begin
        pop     = 1'b1;
        vld_d   = 1'b1;
        addr_d  = head.addr;
        data_d  = head.data;
        state_d = S_ONE;
`ifdef PNQ_SPLIT_EN
        // Spike word carrying a second neuron index in addr[13:7].
        if (!head.addr[14] && (head.addr[13:7] != 7'h00)) begin
          addr_d  = {head.addr[15], 1'b0, 7'h00, head.addr[6:0]};
          hi_d    = {head.addr[15], 1'b0, 7'h00, head.addr[13:7]};
          state_d = S_HI;
        end
`endif
      end else begin
        vld_d   = 1'b0;
        addr_d  = 16'h0;
        data_d  = 32'h0;
        state_d = S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pn_event_queue.sv
module tb_pn_event_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [31:0] in_data;
  logic        stall;
  logic        o_valid;
  logic [15:0] oADDR;
  logic [31:0] oDATA;
  logic [4:0]  fifo_count;
  logic        ovf_err;

  int total = 0;
  int bad   = 0;

  pn_event_queue #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .stall(stall),
    .o_valid(o_valid), .oADDR(oADDR), .oDATA(oDATA),
    .fifo_count(fifo_count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] a,
                         input logic [31:0] d, input logic [4:0] c);
    chk({tag, ".vld"}, 32'(o_valid), 32'(v));
    chk({tag, ".addr"}, 32'(oADDR), 32'(a));
    chk({tag, ".data"}, oDATA, d);
    chk({tag, ".cnt"}, 32'(fifo_count), 32'(c));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 16'h0, 32'h0, 5'd0);
    chk("reset.rdy", 32'(in_ready), 32'd1);
    chk("reset.ovf", 32'(ovf_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single event, minimum latency.
    in_valid = 1'b1; in_addr = 16'h4005; in_data = 32'hA5;
    tick();
    in_valid = 1'b0;
    chk_out("single.push", 1'b0, 16'h0, 32'h0, 5'd1);
    tick();
    chk_out("single.emit", 1'b1, 16'h4005, 32'hA5, 5'd0);
    tick();
    chk_out("single.idle", 1'b0, 16'h0, 32'h0, 5'd0);

    // Fill under stall, then overflow.
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_addr = 16'h4100 + 16'(i); in_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    chk("full.cnt", 32'(fifo_count), 32'd16);
    chk("full.rdy", 32'(in_ready), 32'd0);
    chk("full.ovf_pre", 32'(ovf_err), 32'd0);
    in_addr = 16'hBEEF; in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    chk("ovf.set", 32'(ovf_err), 32'd1);
    chk_out("ovf.hold", 1'b0, 16'h0, 32'h0, 5'd16);

    // Drain in order with no gaps; the dropped word must not appear.
    stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_out($sformatf("drain%0d", i), 1'b1, 16'h4100 + 16'(i),
              32'hD000_0000 + 32'(i), 5'(15 - i));
    end
    chk("drain.rdy", 32'(in_ready), 32'd1);
    tick();
    chk_out("drain.idle", 1'b0, 16'h0, 32'h0, 5'd0);
    chk("drain.ovf_sticky", 32'(ovf_err), 32'd1);

    // Stall holds a live event; simultaneous push+pop leaves count unchanged.
    stall = 1'b1;
    in_valid = 1'b1; in_addr = 16'h4AAA; in_data = 32'h1; tick();
    in_addr = 16'h4BBB; in_data = 32'h2; tick();
    in_valid = 1'b0;
    stall = 1'b0;
    in_valid = 1'b1; in_addr = 16'h4CCC; in_data = 32'h3;
    tick();
    in_valid = 1'b0;
    chk_out("pp.A", 1'b1, 16'h4AAA, 32'h1, 5'd2);
    stall = 1'b1;
    tick(); tick();
    chk_out("pp.hold", 1'b1, 16'h4AAA, 32'h1, 5'd2);
    stall = 1'b0;
    tick();
    chk_out("pp.B", 1'b1, 16'h4BBB, 32'h2, 5'd1);
    tick();
    chk_out("pp.C", 1'b1, 16'h4CCC, 32'h3, 5'd0);
    tick();
    chk_out("pp.idle", 1'b0, 16'h0, 32'h0, 5'd0);

    // Two-neuron spike word, with the split held by a 3-cycle stall.
    in_valid = 1'b1; in_addr = 16'h0283; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    tick();
`ifdef PNQ_SPLIT_EN
    chk_out("split.lo", 1'b1, 16'h0003, 32'h77, 5'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("split.hold%0d", i), 1'b1, 16'h0003, 32'h77, 5'd0);
    end
    stall = 1'b0;
    tick();
    chk_out("split.hi", 1'b1, 16'h0005, 32'h77, 5'd0);
`else
    chk_out("nosplit.word", 1'b1, 16'h0283, 32'h77, 5'd0);
`endif
    tick();
    chk_out("split.idle", 1'b0, 16'h0, 32'h0, 5'd0);

    // Async reset in the middle of a split with entries queued.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = (i == 0) ? 16'h0283 : 16'h4200 + 16'(i); in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    stall = 1'b0;
    tick();
`ifdef PNQ_SPLIT_EN
    chk_out("rstmid.pre", 1'b1, 16'h0003, 32'h0, 5'd3);
`else
    chk_out("rstmid.pre", 1'b1, 16'h0283, 32'h0, 5'd3);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk_out("rstmid.now", 1'b0, 16'h0, 32'h0, 5'd0);
    chk("rstmid.rdy", 32'(in_ready), 32'd1);
    chk("rstmid.ovf", 32'(ovf_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_out("rstmid.after", 1'b0, 16'h0, 32'h0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
